morse_decoder: RTL and testbench

Receive-side counterpart to the Morse keyer path. It samples a keyed on/off line, classifies marks as dot or dash and gaps as element, letter or word breaks, and emits one ASCII byte per decoded character. The byte carries a one-cycle done strobe, the same handshake the UART receiver uses, so the decoder can feed the UART TX FIFO and seven-segment path directly.

---
 rtl/morse_decoder_pkg.sv | 66 ++++++
 rtl/morse_lut.sv | 15 +
 rtl/morse_decoder.sv | 118 +++++++++++
 tb/tb_morse_decoder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/morse_decoder_pkg.sv
// Shared Morse definitions: FSM states, gap/mark thresholds in units,
// ASCII constants and the (len, pat) -> {err, ascii} code table.
package morse_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_GAP,
        ST_WORD
    } state_e;

    localparam int unsigned DASH_UNITS        = 2;
    localparam int unsigned LETTER_GAP_UNITS  = 2;
    localparam int unsigned WORD_GAP_UNITS    = 5;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ERR   = 8'h3F;
    localparam logic [2:0] LEN_OVF     = 3'd6;

    // pat holds the elements MSB-first within its low len bits (1 = dash).
    function automatic logic [8:0] morse_code(input logic [2:0] len, input logic [4:0] pat);
        logic [8:0] code;
        code = {1'b1, ASCII_ERR};
        case ({len, pat})
            {3'd1, 5'b00000}: code = {1'b0, 8'h45}; // E
            {3'd1, 5'b00001}: code = {1'b0, 8'h54}; // T
            {3'd2, 5'b00001}: code = {1'b0, 8'h41}; // A
            {3'd2, 5'b00000}: code = {1'b0, 8'h49}; // I
            {3'd2, 5'b00011}: code = {1'b0, 8'h4D}; // M
            {3'd2, 5'b00010}: code = {1'b0, 8'h4E}; // N
            {3'd3, 5'b00100}: code = {1'b0, 8'h44}; // D
            {3'd3, 5'b00110}: code = {1'b0, 8'h47}; // G
            {3'd3, 5'b00101}: code = {1'b0, 8'h4B}; // K
            {3'd3, 5'b00111}: code = {1'b0, 8'h4F}; // O
            {3'd3, 5'b00010}: code = {1'b0, 8'h52}; // R
            {3'd3, 5'b00000}: code = {1'b0, 8'h53}; // S
            {3'd3, 5'b00001}: code = {1'b0, 8'h55}; // U
            {3'd3, 5'b00011}: code = {1'b0, 8'h57}; // W
            {3'd4, 5'b01000}: code = {1'b0, 8'h42}; // B
            {3'd4, 5'b01010}: code = {1'b0, 8'h43}; // C
            {3'd4, 5'b00010}: code = {1'b0, 8'h46}; // F
            {3'd4, 5'b00000}: code = {1'b0, 8'h48}; // H
            {3'd4, 5'b00111}: code = {1'b0, 8'h4A}; // J
            {3'd4, 5'b00100}: code = {1'b0, 8'h4C}; // L
            {3'd4, 5'b00110}: code = {1'b0, 8'h50}; // P
            {3'd4, 5'b01101}: code = {1'b0, 8'h51}; // Q
            {3'd4, 5'b00001}: code = {1'b0, 8'h56}; // V
            {3'd4, 5'b01001}: code = {1'b0, 8'h58}; // X
            {3'd4, 5'b01011}: code = {1'b0, 8'h59}; // Y
            {3'd4, 5'b01100}: code = {1'b0, 8'h5A}; // Z
            {3'd5, 5'b11111}: code = {1'b0, 8'h30};
            {3'd5, 5'b01111}: code = {1'b0, 8'h31};
            {3'd5, 5'b00111}: code = {1'b0, 8'h32};
            {3'd5, 5'b00011}: code = {1'b0, 8'h33};
            {3'd5, 5'b00001}: code = {1'b0, 8'h34};
            {3'd5, 5'b00000}: code = {1'b0, 8'h35};
            {3'd5, 5'b10000}: code = {1'b0, 8'h36};
            {3'd5, 5'b11000}: code = {1'b0, 8'h37};
            {3'd5, 5'b11100}: code = {1'b0, 8'h38};
            {3'd5, 5'b11110}: code = {1'b0, 8'h39};
            default:          code = {1'b1, ASCII_ERR};
        endcase
        return code;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse character lookup: (len, pat) -> {err, ascii}.
module morse_lut
    import morse_decoder_pkg::*;
(
    input  logic [2:0] len_i,
    input  logic [4:0] pat_i,
    output logic       err_o,
    output logic [7:0] ascii_o
);

    always_comb begin
        {err_o, ascii_o} = morse_code(len_i, pat_i);
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: synchronises the keyed line, times marks and gaps and emits
// one ASCII byte per character (plus a space per word break) with a done strobe.
module morse_decoder
    import morse_decoder_pkg::*;
#(
    parameter  int unsigned UNIT_CYCLES = 6_000_000,
    localparam int unsigned CNT_W       = $clog2(8 * UNIT_CYCLES)
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       morse_i,
    output logic [7:0] data_o,
    output logic       done_o,
    output logic       error_o,
    output logic       busy_o
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DASH_TC   = cnt_t'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam cnt_t LETTER_TC = cnt_t'(LETTER_GAP_UNITS * UNIT_CYCLES - 1);
    localparam cnt_t WORD_TC   = cnt_t'(WORD_GAP_UNITS * UNIT_CYCLES - 1);

    state_e     state_q, state_d;
    logic       sync1_q, s_q, s_prev_q;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] len_q, len_d;
    logic [4:0] pat_q, pat_d;
    logic [7:0] data_q;
    logic       rise, fall, s_edge, is_dash;
    logic       emit_char, emit_space;
    logic       lut_err;
    logic [7:0] lut_ascii;

    assign rise    = s_q & ~s_prev_q;
    assign fall    = ~s_q & s_prev_q;
    assign s_edge  = rise | fall;
    // cnt >= 2U-1 is L >= 2U without widening, and keeps saturated marks as dashes.
    assign is_dash = (cnt_q >= DASH_TC);

    morse_lut u_lut (
        .len_i   (len_q),
        .pat_i   (pat_q),
        .err_o   (lut_err),
        .ascii_o (lut_ascii)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rise) state_d = ST_MARK;
            ST_MARK: if (fall) state_d = ST_GAP;
            ST_GAP: begin
                if (rise)                    state_d = ST_MARK;
                else if (cnt_q == LETTER_TC) state_d = ST_WORD;
            end
            ST_WORD: begin
                if (rise)                  state_d = ST_MARK;
                else if (cnt_q == WORD_TC) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A rising edge on a terminal count suppresses the emission.
    always_comb begin
        emit_char  = (state_q == ST_GAP)  && !rise && (cnt_q == LETTER_TC);
        emit_space = (state_q == ST_WORD) && !rise && (cnt_q == WORD_TC);
        done_o     = emit_char | emit_space;
        error_o    = emit_char & lut_err;
        busy_o     = (state_q != ST_IDLE);
        if (emit_char)       data_o = lut_ascii;
        else if (emit_space) data_o = ASCII_SPACE;
        else                 data_o = data_q;
    end

    always_comb begin
        cnt_d = s_edge ? '0 : ((&cnt_q) ? cnt_q : cnt_q + cnt_t'(1));
        len_d = len_q;
        pat_d = pat_q;
        if (emit_char) begin
            len_d = '0;
            pat_d = '0;
        end else if ((state_q == ST_MARK) && fall) begin
            pat_d = {pat_q[3:0], is_dash};
            len_d = (len_q == LEN_OVF) ? LEN_OVF : len_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q  <= 1'b0;
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
            cnt_q    <= '0;
            len_q    <= '0;
            pat_q    <= '0;
            data_q   <= '0;
        end else begin
            sync1_q  <= morse_i;
            s_q      <= sync1_q;
            s_prev_q <= s_q;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            pat_q    <= pat_d;
            data_q   <= data_o;
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder at UNIT_CYCLES=4: strobes are logged with
// their cycle number and compared against hand-computed bytes and latencies.
module tb_morse_decoder;

    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic       morse_i = 1'b0;
    logic [7:0] data_o;
    logic       done_o, error_o, busy_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          cyc = 0;
    int          fall_k = 0;
    logic        double_strobe = 1'b0;
    logic        stray_error = 1'b0;
    logic        prev_done = 1'b0;
    logic        busy_seen = 1'b0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       err;
    } ev_t;

    ev_t evq[$];

    morse_decoder #(.UNIT_CYCLES(4)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .morse_i  (morse_i),
        .data_o   (data_o),
        .done_o   (done_o),
        .error_o  (error_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (done_o) evq.push_back('{cyc: cyc, data: data_o, err: error_o});
        if (done_o && prev_done) double_strobe = 1'b1;
        if (error_o && !done_o) stray_error = 1'b1;
        prev_done = done_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mark for `mark` clocks then silence for `space` clocks; call at a negedge.
    task automatic elem(input int mark, input int space);
        morse_i = 1'b1;
        repeat (mark) @(negedge clk_i);
        morse_i = 1'b0;
        fall_k = cyc;
        repeat (space) @(negedge clk_i);
    endtask

    task automatic check_ev(input string tag, input int idx, input logic [7:0] data, input logic err);
        if (idx < evq.size()) begin
            check({tag, "_data"}, 32'(evq[idx].data), 32'(data));
            check({tag, "_err"}, 32'(evq[idx].err), 32'(err));
        end
    endtask

    // Single letter followed by a long silence: letter then space expected.
    task automatic letter_case(input string tag, input logic [7:0] data, input logic err);
        check({tag, "_count"}, evq.size(), 2);
        check_ev(tag, 0, data, err);
        check_ev({tag, "_sp"}, 1, 8'h20, 1'b0);
        evq.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        reset_ni = 1'b1;

        // Idle line
        repeat (100) begin
            @(negedge clk_i);
            if (busy_o) busy_seen = 1'b1;
        end
        check("idle_data", 32'(data_o), 32'h00);
        check("idle_busy_seen", 32'(busy_seen), 0);
        check("idle_strobes", evq.size(), 0);

        // "E": latencies relative to the cycle the line was dropped (+2 sync)
        elem(4, 40);
        check("E_count", evq.size(), 2);
        check_ev("E", 0, 8'h45, 1'b0);
        check_ev("E_sp", 1, 8'h20, 1'b0);
        if (evq.size() >= 2) begin
            check("E_letter_lat", evq[0].cyc - fall_k, 2 + 8);
            check("E_space_lat", evq[1].cyc - fall_k, 2 + 20);
        end
        check("E_data_hold", 32'(data_o), 32'h20);
        check("E_busy_after", 32'(busy_o), 0);
        evq.delete();

        // "A" (.-), 12-cycle gap, "N" (-.)
        elem(4, 4);
        elem(8, 12);
        elem(8, 4);
        elem(4, 40);
        check("AN_count", evq.size(), 3);
        check_ev("AN_A", 0, 8'h41, 1'b0);
        check_ev("AN_N", 1, 8'h4E, 1'b0);
        check_ev("AN_sp", 2, 8'h20, 1'b0);
        evq.delete();

        // Mark-length boundary
        elem(7, 40);
        letter_case("mark7", 8'h45, 1'b0);
        elem(8, 40);
        letter_case("mark8", 8'h54, 1'b0);
        elem(60, 40);
        letter_case("mark60", 8'h54, 1'b0);

        // Five dashes -> '0'
        repeat (4) elem(8, 4);
        elem(8, 40);
        letter_case("zero", 8'h30, 1'b0);

        // Six dots -> overflow
        repeat (5) elem(4, 4);
        elem(4, 40);
        letter_case("six_dots", 8'h3F, 1'b1);

        // .-.- is not in the table
        elem(4, 4);
        elem(8, 4);
        elem(4, 4);
        elem(8, 40);
        letter_case("dot_dash_x2", 8'h3F, 1'b1);

        // Reset in the middle of a dash
        morse_i = 1'b1;
        repeat (5) @(negedge clk_i);
        reset_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        morse_i = 1'b0;
        reset_ni = 1'b1;
        repeat (40) @(negedge clk_i);
        check("rst_strobes", evq.size(), 0);
        check("rst_data", 32'(data_o), 32'h00);
        check("rst_busy", 32'(busy_o), 0);
        elem(4, 40);
        letter_case("rst_E", 8'h45, 1'b0);

        check("no_double_strobe", 32'(double_strobe), 0);
        check("no_stray_error", 32'(stray_error), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
